// File: rtl/div_param.sv
// Purpose : parameterised restoring divider, signed/unsigned, optional fixed-point quotient bits.
// Latency : result strobed WIDTH+FRAC cycles after an accepted start; 1 cycle for divide-by-zero.
// Backpr. : none; start is accepted only in IDLE/DONE and dropped silently while busy.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   start, sgn      - request a division; sgn=1 treats A/B as two's complement
//   A, B            - dividend / divisor, captured on the accepting edge
//   Q, R            - quotient / remainder, held until the next accepted start
//   busy, valid     - division in progress / one-cycle result strobe
//   ov, dvz         - quotient does not fit in WIDTH bits / divisor was zero
module div_param #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             valid,
  output logic             ov,
  output logic             dvz
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Magnitude of the most negative signed result (2^(WIDTH-1)).
  localparam logic [N-1:0] SLIM = N'(1) << (WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     sh;       // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             sgn_r;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_nx;
  logic [N-1:0]     sh_nx;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic             ov_fin;

  assign a_neg = sgn & A[WIDTH-1];
  assign b_neg = sgn & B[WIDTH-1];
  // -(most negative) wraps to 2^(WIDTH-1), which is the right magnitude read as unsigned.
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // One restoring step. rem < dvs always, so the difference fits in WIDTH bits.
  assign trial  = {rem, sh[N-1]};
  assign take   = (trial >= {1'b0, dvs});
  assign rem_nx = take ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
  assign sh_nx  = {sh[N-2:0], take};

  // Final-step results; the low bits of a negation only depend on the low bits.
  assign q_fin  = q_neg ? -sh_nx[WIDTH-1:0] : sh_nx[WIDTH-1:0];
  assign r_fin  = r_neg ? -rem_nx : rem_nx;
  assign ov_fin = sgn_r ? (q_neg ? (sh_nx > SLIM) : (sh_nx >= SLIM))
                        : ((sh_nx >> WIDTH) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sh    <= '0;
      rem   <= '0;
      dvs   <= '0;
      sgn_r <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      ov    <= 1'b0;
      dvz   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            ov    <= 1'b0;
            sgn_r <= sgn;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            cnt   <= '0;
            if (B == '0) begin
              // Zero divisor short-circuits straight to a result.
              state <= S_DONE;
              Q     <= '0;
              R     <= '0;
              dvz   <= 1'b1;
              valid <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_RUN;
              dvz   <= 1'b0;
              busy  <= 1'b1;
              dvs   <= b_mag;
              rem   <= '0;
              sh    <= N'(a_mag) << FRAC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          rem <= rem_nx;
          sh  <= sh_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
            Q     <= q_fin;
            R     <= r_fin;
            ov    <= ov_fin;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_param.sv
// Bench for div_param: two instances (FRAC=0 and FRAC=4, WIDTH=10), a vector table,
// hand-written multi-cycle sequences and random operations against an arithmetic model.
module tb_div_param;

  typedef struct packed {
    logic [9:0] q;
    logic [9:0] r;
    logic       ov;
    logic       dvz;
  } res_t;

  typedef struct {
    int         w;   // 0 -> FRAC=0 instance, 1 -> FRAC=4 instance
    logic       s;
    logic [9:0] a;
    logic [9:0] b;
    res_t       e;
  } vec_t;

  logic       clk, rst, sgn, start0, start4;
  logic [9:0] A, B;
  logic [9:0] q0, r0, q4, r4;
  logic       busy0, valid0, ov0, dvz0;
  logic       busy4, valid4, ov4, dvz4;

  int total = 0;
  int bad   = 0;

  div_param #(.WIDTH(10), .FRAC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .sgn(sgn), .A(A), .B(B),
    .Q(q0), .R(r0), .busy(busy0), .valid(valid0), .ov(ov0), .dvz(dvz0)
  );

  div_param #(.WIDTH(10), .FRAC(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn), .A(A), .B(B),
    .Q(q4), .R(r4), .busy(busy4), .valid(valid4), .ov(ov4), .dvz(dvz4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] qo(input int w); return w != 0 ? q4 : q0; endfunction
  function automatic logic [9:0] ro(input int w); return w != 0 ? r4 : r0; endfunction
  function automatic logic bo(input int w); return w != 0 ? busy4 : busy0; endfunction
  function automatic logic vo(input int w); return w != 0 ? valid4 : valid0; endfunction
  function automatic logic oo(input int w); return w != 0 ? ov4 : ov0; endfunction
  function automatic logic zo(input int w); return w != 0 ? dvz4 : dvz0; endfunction

  // Reference: (A << frac) / B in plain integer arithmetic, truncating toward zero.
  function automatic res_t model(input int frac, input logic s, input logic [9:0] a, input logic [9:0] b);
    res_t   res;
    longint av, bv, num, quo, rm;
    res = '0;
    if (b == 10'd0) begin
      res.dvz = 1'b1;
      return res;
    end
    if (s) begin
      av = longint'($signed(a));
      bv = longint'($signed(b));
    end else begin
      av = longint'(a);
      bv = longint'(b);
    end
    num = av * (longint'(1) << frac);
    quo = num / bv;
    rm  = num % bv;
    res.q  = quo[9:0];
    res.r  = rm[9:0];
    res.ov = s ? (quo > 511 || quo < -512) : (quo > 1023);
    return res;
  endfunction

  function automatic vec_t mk(input int w, input logic s, input logic [9:0] a, input logic [9:0] b,
                              input logic [9:0] q, input logic [9:0] r, input logic ov, input logic dvz);
    vec_t v;
    v.w = w; v.s = s; v.a = a; v.b = b;
    v.e.q = q; v.e.r = r; v.e.ov = ov; v.e.dvz = dvz;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Presents an operation for one clock; returns 1ns after the accepting edge.
  task automatic launch(input int w, input logic s, input logic [9:0] a, input logic [9:0] b);
    @(negedge clk);
    sgn = s; A = a; B = b;
    if (w != 0) start4 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start4 = 1'b0;
  endtask

  // Waits for valid, counting falling edges; lat is edges after the accepting one.
  task automatic collect(input int w, input int exp_lat, input logic bz, input res_t e, input string nm);
    int   lat;
    logic busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!vo(w) && lat < 200) begin
      if (bo(w) !== !bz) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bo(w) !== 1'b0) busy_ok = 1'b0;
    chk({nm, "_valid"}, vo(w), 1);
    chk({nm, "_lat"},   lat, exp_lat);
    chk({nm, "_busy"},  busy_ok, 1);
    chk({nm, "_q"},     qo(w), e.q);
    chk({nm, "_r"},     ro(w), e.r);
    chk({nm, "_ov"},    oo(w), e.ov);
    chk({nm, "_dvz"},   zo(w), e.dvz);
  endtask

  vec_t vt[14];

  initial begin
    rst = 1'b1; start0 = 1'b0; start4 = 1'b0; sgn = 1'b0; A = '0; B = '0;

    vt[0]  = mk(0, 0, 10'd175, 10'd16,  10'd10,  10'd15,  0, 0);
    vt[1]  = mk(0, 0, 10'd848, 10'd0,   10'd0,   10'd0,   0, 1);
    vt[2]  = mk(0, 1, 10'h39C, 10'd8,   10'h3F4, 10'h3FC, 0, 0);
    vt[3]  = mk(0, 1, 10'h200, 10'h3FF, 10'h200, 10'd0,   1, 0);
    vt[4]  = mk(1, 0, 10'd175, 10'd16,  10'd175, 10'd0,   0, 0);
    vt[5]  = mk(1, 0, 10'd1000, 10'd3,  10'd213, 10'd1,   1, 0);
    vt[6]  = mk(0, 0, 10'd1023, 10'd1,  10'd1023, 10'd0,  0, 0);
    vt[7]  = mk(0, 0, 10'd5,   10'd7,   10'd0,   10'd5,   0, 0);
    vt[8]  = mk(0, 1, 10'd7,   10'h3FE, 10'h3FD, 10'd1,   0, 0);
    vt[9]  = mk(0, 1, 10'h3F9, 10'h3FE, 10'd3,   10'h3FF, 0, 0);
    vt[10] = mk(1, 1, 10'h3FF, 10'd2,   10'h3F8, 10'd0,   0, 0);
    vt[11] = mk(1, 0, 10'd1,   10'd3,   10'd5,   10'd1,   0, 0);
    vt[12] = mk(0, 1, 10'h200, 10'd1,   10'h200, 10'd0,   0, 0);
    vt[13] = mk(1, 0, 10'd0,   10'd0,   10'd0,   10'd0,   0, 1);

    // Reset state.
    #2 rst = 1'b0;
    #1;
    chk("rst_q0", q0, 0);   chk("rst_r0", r0, 0);
    chk("rst_busy0", busy0, 0); chk("rst_valid0", valid0, 0);
    chk("rst_ov0", ov0, 0); chk("rst_dvz0", dvz0, 0);
    chk("rst_busy4", busy4, 0); chk("rst_valid4", valid4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Table vectors.
    for (int i = 0; i < 14; i++) begin
      launch(vt[i].w, vt[i].s, vt[i].a, vt[i].b);
      collect(vt[i].w, (vt[i].b == 10'd0) ? 0 : (vt[i].w != 0 ? 14 : 10),
              vt[i].b == 10'd0, vt[i].e, $sformatf("vec%0d", i));
    end

    // Start during RUN is ignored and operand changes do not leak in.
    launch(0, 1'b0, 10'd175, 10'd16);
    repeat (3) @(negedge clk);
    start0 = 1'b1; A = 10'd1; B = 10'd1;
    @(negedge clk);
    start0 = 1'b0; A = 10'd5; B = 10'd9;
    collect(0, 6, 1'b0, model(0, 1'b0, 10'd175, 10'd16), "rerun");

    // Start in the DONE cycle: busy follows valid with no idle gap.
    start0 = 1'b1; sgn = 1'b0; A = 10'd100; B = 10'd7;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("b2b_busy", busy0, 1);
    chk("b2b_valid_low", valid0, 0);
    collect(0, 10, 1'b0, model(0, 1'b0, 10'd100, 10'd7), "b2b");

    // Results hold after DONE.
    repeat (3) @(negedge clk);
    chk("hold_q", q0, 14); chk("hold_r", r0, 2); chk("hold_valid", valid0, 0);

    // Reset mid-run: immediate clear, no valid, start ignored while low.
    launch(0, 1'b0, 10'd175, 10'd16);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_q", q0, 0); chk("abort_r", r0, 0); chk("abort_busy", busy0, 0);
    chk("abort_valid", valid0, 0); chk("abort_ov", ov0, 0); chk("abort_dvz", dvz0, 0);
    begin
      logic seen;
      seen = 1'b0;
      start0 = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (valid0 || busy0) seen = 1'b1;
      end
      start0 = 1'b0;
      chk("abort_quiet", seen, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("release_idle", busy0, 0);
    launch(0, 1'b0, 10'd24, 10'd24);
    collect(0, 10, 1'b0, '{q: 10'd1, r: 10'd0, ov: 1'b0, dvz: 1'b0}, "after_rst");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      int         w;
      logic       s;
      logic [9:0] a, b;
      w = int'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = 10'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom);
      launch(w, s, a, b);
      collect(w, (b == 10'd0) ? 0 : (w != 0 ? 14 : 10), b == 10'd0,
              model(w != 0 ? 4 : 0, s, a, b), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_param.md
DIV_PARAM -- requirements
Module: div_param

Parameters
REQ-001 SHALL provide WIDTH, default 10: operand, quotient and remainder width in bits, legal range 4..32.
REQ-002 SHALL provide FRAC, default 0: fractional quotient bits, so the quotient is (A << FRAC) / B, legal range 0..WIDTH-1.

Interface
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled on the rising edge.
REQ-006 SHALL have port sgn, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port A, input, WIDTH bits: dividend.
REQ-008 SHALL have port B, input, WIDTH bits: divisor.
REQ-009 SHALL have port Q, output, WIDTH bits: quotient.
REQ-010 SHALL have port R, output, WIDTH bits: remainder.
REQ-011 SHALL have port busy, output, 1 bit: a division is in progress.
REQ-012 SHALL have port valid, output, 1 bit: one-cycle result strobe.
REQ-013 SHALL have port ov, output, 1 bit: quotient overflow.
REQ-014 SHALL have port dvz, output, 1 bit: divide by zero.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE; N = WIDTH+FRAC iterations.
REQ-016 SHALL accept start only in IDLE or DONE (back-to-back allowed); start in RUN ignored, operands unchanged.
REQ-017 On acceptance at edge t0 SHALL capture A, B and sgn, clear ov/dvz, and take magnitudes |A| and |B| when sgn=1.
REQ-018 If B==0 at t0 SHALL go directly to DONE: Q=0, R=0, dvz=1, ov=0, busy never asserted.
REQ-019 Otherwise SHALL enter RUN at t0; restoring shift-subtract produces one quotient bit per edge over edges t0+1..t0+N; busy=1 throughout RUN.
REQ-020 At edge t0+N SHALL enter DONE; valid=1 for exactly the DONE cycle; busy=0 in IDLE and DONE.
REQ-021 DONE SHALL return to IDLE on the next edge unless start is accepted.
REQ-022 Unsigned arithmetic: internal quotient N bits; ov=1 if any of the upper FRAC bits is nonzero; Q = the lower WIDTH bits, truncated.
REQ-023 Signed arithmetic: quotient negated when sign(A) xor sign(B); R carries the sign of A; truncation toward zero.
REQ-024 Signed overflow: ov=1 if the signed result exceeds 2^(WIDTH-1)-1 or is below -2^(WIDTH-1), including most-negative / -1 with FRAC=0.
REQ-025 When ov=1, Q SHALL equal the truncated lower WIDTH bits and R SHALL remain correct.
REQ-026 Q, R, ov and dvz SHALL hold their values after DONE until the next accepted start.
REQ-027 A and B changing during RUN SHALL NOT affect the result.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE: Q=0, R=0, busy=0, valid=0, ov=0, dvz=0, iteration counter 0.
REQ-029 Reset asserted mid-RUN SHALL abort the division with no valid pulse; the first start after release SHALL run normally.
REQ-030 start SHALL be ignored while rst=0.

Verification
REQ-031 WIDTH=10, FRAC=0, sgn=0; A=175, B=16 -> valid at t0+10 cycles, Q=10, R=15, ov=0, dvz=0.
REQ-032 A=848, B=0 -> valid one cycle after t0, busy never 1, dvz=1, Q=0, R=0.
REQ-033 sgn=1; A=-100 (0x39C), B=8 -> Q=-12 (0x3F4), R=-4 (0x3FC); then A=-512, B=-1 -> ov=1.
REQ-034 WIDTH=10, FRAC=4; A=175, B=16 -> Q=175, R=0, valid at t0+14; A=1000, B=3 -> ov=1.
REQ-035 rst pulsed low at t0+5 of a running division -> all outputs 0 immediately, no valid; a following start with A=24, B=24 -> Q=1, R=0.
REQ-036 Start re-asserted during RUN is ignored (the original result is delivered); start asserted in the DONE cycle is accepted with no idle gap between valid and the new busy.
